// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: recovers start/data/stop frames from an
// asynchronous RXD line and hands each byte over on a valid/ready port,
// with sticky framing-error and overrun flags.
module uart_rx_deserializer #(
   parameter int unsigned CLKS_PER_BIT = 64,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 RXD,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   input  logic                 err_clr,
   output logic                 busy
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] MID      = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic                 rxd_meta_q, rxd_meta_d;
   logic                 rxd_s_q, rxd_s_d;
   logic                 rxd_prev_q, rxd_prev_d;
   logic [1:0]           flush_q, flush_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 fall;
   logic                 wrap;
   logic                 deliver;
   logic                 stop_bad;

   // Two-flop synchroniser and falling-edge detect. The edge history only
   // arms once the reset-loaded ones have been flushed out of the
   // synchroniser, so a line that is already low at reset exit never
   // looks like a start bit.
   always_comb begin
      rxd_meta_d = RXD;
      rxd_s_d    = rxd_meta_q;
      flush_d    = {flush_q[0], 1'b1};
      rxd_prev_d = flush_q[1] & rxd_s_q;
      fall       = rxd_prev_q & ~rxd_s_q;
   end

   // Frame FSM next-state, bit timing and shift register.
   always_comb begin
      state_d  = state_q;
      wrap     = (cnt_q == LAST);
      cnt_d    = wrap ? '0 : cnt_q + 1'b1;
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      deliver  = 1'b0;
      stop_bad = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (fall) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == MID) begin
               if (!rxd_s_q) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (wrap) begin
               shreg_d = {rxd_s_q, shreg_q[DATA_BITS-1:1]};
               if (idx_q == LAST_IDX) begin
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_STOP: begin
            if (wrap) begin
               deliver  = 1'b1;
               stop_bad = ~rxd_s_q;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output holding register, handshake and sticky error flags.
   always_comb begin
      data_d  = deliver ? shreg_q : data_q;
      valid_d = deliver | (valid_q & ~rx_ready);
      ovr_d   = (err_clr ? 1'b0 : ovr_q) | (deliver & valid_q & ~rx_ready);
      ferr_d  = (err_clr ? 1'b0 : ferr_q) | stop_bad;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q    <= S_IDLE;
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
         rxd_prev_q <= 1'b0;
         flush_q    <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         shreg_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rxd_meta_q <= rxd_meta_d;
         rxd_s_q    <= rxd_s_d;
         rxd_prev_q <= rxd_prev_d;
         flush_q    <= flush_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shreg_q    <= shreg_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: table of single frames, hand-written
// corner sequences, and a randomized stream checked against a byte queue.
module tb_uart_rx_deserializer;

   localparam int CPB = 64;
   localparam int DB  = 8;
   localparam int LAT = 2 + (CPB / 2 - 1) + (DB + 1) * CPB + 1;

   logic          HCLK     = 1'b0;
   logic          HRESETn  = 1'b0;
   logic          RXD      = 1'b1;
   logic          rx_ready = 1'b0;
   logic          err_clr  = 1'b0;
   logic [DB-1:0] rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic          overrun;
   logic          busy;

   uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .RXD       (RXD),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .err_clr   (err_clr),
      .busy      (busy)
   );

   always #5 HCLK = ~HCLK;

   int vec_cnt = 0;
   int err_cnt = 0;
   int vhigh_cnt = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   // Every accepted byte (valid & ready at the coming edge) is logged.
   always @(negedge HCLK) begin
      if (HRESETn && rx_valid) begin
         vhigh_cnt++;
         if (rx_ready) got_q.push_back(rx_data);
      end
   end

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic [7:0] exp_data;
      logic       exp_ferr;
   } vec_t;

   vec_t tbl[5];

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_lat(input string name, input int lat);
      vec_cnt++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
         err_cnt++;
         $display("FAIL %s: latency %0d expected %0d..%0d", name, lat, LAT - 1, LAT + 1);
      end
   endtask

   task automatic drive_bit(input logic b);
      RXD = b;
      repeat (CPB) tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < DB; i++) drive_bit(d[i]);
      drive_bit(stop);
      RXD = 1'b1;
   endtask

   task automatic wait_valid(output int lat);
      lat = -1;
      for (int n = 1; n <= LAT + 200; n++) begin
         tick();
         if (rx_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [7:0] d;
      logic stop;
      logic exp_ferr;
      int gap;

      tbl[0] = '{8'h93, 1'b1, 8'h93, 1'b0};
      tbl[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
      tbl[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
      tbl[3] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
      tbl[4] = '{8'hA5, 1'b1, 8'hA5, 1'b0};

      // Reset with the line held low; it must not be taken as a start bit.
      RXD = 1'b0;
      HRESETn = 1'b0;
      repeat (5) tick();
      check("rst_data", rx_data, 0);
      check("rst_valid", rx_valid, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", overrun, 0);
      check("rst_busy", busy, 0);
      HRESETn = 1'b1;
      repeat (100) tick();
      check("low_at_reset_busy", busy, 0);
      RXD = 1'b1;
      repeat (10) tick();

      // Table-driven single frames, consumer holding off until checked.
      for (int i = 0; i < 5; i++) begin
         rx_ready = 1'b0;
         fork
            send_frame(tbl[i].data, tbl[i].stop);
            wait_valid(lat);
         join
         check_lat("tbl_latency", lat);
         check("tbl_data", rx_data, tbl[i].exp_data);
         check("tbl_valid", rx_valid, 1);
         check("tbl_ferr", frame_err, tbl[i].exp_ferr);
         check("tbl_ovr", overrun, 0);
         check("tbl_busy", busy, 0);
         rx_ready = 1'b1;
         err_clr  = 1'b1;
         tick();
         rx_ready = 1'b0;
         err_clr  = 1'b0;
         check("tbl_valid_cleared", rx_valid, 0);
         check("tbl_ferr_cleared", frame_err, 0);
         check("tbl_data_held", rx_data, tbl[i].exp_data);
      end

      // err_clr held through a bad-stop frame: the set must win.
      err_clr = 1'b1;
      fork
         send_frame(8'h3C, 1'b0);
         begin
            wait_valid(lat);
            check("clr_vs_set_ferr", frame_err, 1);
            err_clr = 1'b0;
         end
      join
      rx_ready = 1'b1;
      err_clr  = 1'b1;
      tick();
      rx_ready = 1'b0;
      err_clr  = 1'b0;
      check("clr_vs_set_cleared", frame_err, 0);

      // Back-to-back frames with the consumer always ready.
      rx_ready = 1'b1;
      got_q.delete();
      vhigh_cnt = 0;
      send_frame(8'h55, 1'b1);
      send_frame(8'hA0, 1'b1);
      repeat (20) tick();
      check("b2b_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("b2b_first", got_q[0], 8'h55);
         check("b2b_second", got_q[1], 8'hA0);
      end
      check("b2b_valid_cycles", vhigh_cnt, 2);
      check("b2b_ferr", frame_err, 0);
      check("b2b_ovr", overrun, 0);

      // Short low glitch: start qualifies as false at the mid-sample.
      got_q.delete();
      RXD = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == 20) RXD = 1'b1;
         if (i == 30) check("glitch_busy_high", busy, 1);
      end
      check("glitch_busy_low", busy, 0);
      repeat (200) tick();
      check("glitch_no_byte", got_q.size(), 0);
      check("glitch_valid", rx_valid, 0);
      check("glitch_ferr", frame_err, 0);

      // Overrun: two frames with no consumer; newest byte wins.
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      repeat (5) tick();
      check("ovr_data", rx_data, 8'h22);
      check("ovr_flag", overrun, 1);
      check("ovr_valid", rx_valid, 1);
      check("ovr_ferr", frame_err, 0);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      check("ovr_valid_cleared", rx_valid, 0);
      check("ovr_sticky", overrun, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("ovr_cleared", overrun, 0);

      // Reset in the middle of the data bits abandons the frame.
      rx_ready = 1'b1;
      d = 8'h0F;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      HRESETn = 1'b0;
      RXD = 1'b1;
      repeat (5) tick();
      check("midrst_busy", busy, 0);
      check("midrst_valid", rx_valid, 0);
      HRESETn = 1'b1;
      repeat (10) tick();
      got_q.delete();
      fork
         send_frame(8'h7E, 1'b1);
         wait_valid(lat);
      join
      check_lat("midrst_latency", lat);
      check("midrst_data", rx_data, 8'h7E);
      check("midrst_ferr", frame_err, 0);
      check("midrst_ovr", overrun, 0);
      repeat (5) tick();
      check("midrst_count", got_q.size(), 1);
      if (got_q.size() == 1) check("midrst_byte", got_q[0], 8'h7E);

      // Randomized stream against a queue model.
      got_q.delete();
      exp_q.delete();
      exp_ferr = 1'b0;
      for (int f = 0; f < 10; f++) begin
         d    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         send_frame(d, stop);
         exp_q.push_back(d);
         if (!stop) exp_ferr = 1'b1;
         gap = stop ? int'($urandom_range(0, 30)) : int'($urandom_range(5, 30));
         repeat (gap) tick();
      end
      repeat (20) tick();
      check("rand_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check("rand_byte", got_q[i], exp_q[i]);
      end
      check("rand_ferr", frame_err, exp_ferr);
      check("rand_ovr", overrun, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive end of the serial link the system exposes on its RXD pins. Recovers 10-bit UART frames: start bit 0, 8 data bits LSB first, stop bit 1.
- Presents each received byte on a valid/ready interface to the APB UART register logic.
- Flags framing errors and overruns.
- One clock domain (HCLK). The RXD input is asynchronous and is synchronised internally.

Parameters:
- CLKS_PER_BIT, 64, HCLK cycles per bit period (system default: 32 PCLK at PCLK = HCLK/2); legal range 8..4095.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- HCLK  input  1  system clock; all logic on the rising edge.
- HRESETn  input  1  reset, synchronous, active-low.
- RXD  input  1  serial line, idles high, asynchronous to HCLK.
- rx_data  output  DATA_BITS  received byte, LSB = first data bit on the line.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte in a cycle where rx_valid & rx_ready.
- frame_err  output  1  sticky: a stop bit was sampled as 0.
- overrun  output  1  sticky: a frame completed while rx_valid was still high.
- err_clr  input  1  clears frame_err and overrun for one cycle.
- busy  output  1  FSM is not IDLE.

Behaviour:
- Reset (HRESETn low at a rising edge): the following clear in that same cycle.
  - FSM goes to IDLE.
  - rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0.
  - Both synchroniser flops load 1.
  - Reset asserted mid-frame abandons the frame; no partial byte is ever presented.
- Synchroniser: RXD passes through 2 flops to give rxd_s. All decisions use rxd_s, which is 2 cycles late; that latency is uniform across the frame.
- Bit counter: cnt counts 0..CLKS_PER_BIT-1. mid = (CLKS_PER_BIT/2)-1, using integer division.
- IDLE
  - Falling edge on rxd_s (previous 1, current 0) -> START with cnt = 0.
  - A line held low at reset exit produces no edge and is ignored.
- START
  - At cnt == mid, sample rxd_s.
  - Sample 0: go to DATA with cnt = 0 and bit index = 0.
  - Sample 1: treat as a glitch, return to IDLE, no flags raised.
- DATA
  - Each bit is sampled when cnt wraps from CLKS_PER_BIT-1 to 0, which is one full bit period after the previous mid-sample.
  - Each sample shifts into the shift register from the MSB side; after DATA_BITS samples, shreg[0] is the first bit.
  - After DATA_BITS samples -> STOP.
- STOP
  - Sample at the next wrap.
  - Sample 1: the frame is good.
  - Sample 0: set frame_err; the byte is still delivered.
  - Either way return to IDLE in the same cycle. IDLE re-arms immediately, so back-to-back frames need no extra idle time.
- Delivery (same cycle as the stop sample):
  - rx_data <= shreg and rx_valid <= 1, registered. The outputs are visible 1 cycle after the stop sample.
  - If rx_valid was already 1 and no handshake occurs in that cycle: set overrun and overwrite rx_data with the new byte.
  - If a handshake and a delivery coincide: the new byte wins, rx_valid stays 1, no overrun.
- Handshake
  - rx_valid & rx_ready with no delivery -> rx_valid <= 0 next cycle; rx_data holds its value.
  - rx_ready while rx_valid is 0 has no effect.
- Error flags
  - err_clr clears both flags.
  - err_clr in the same cycle as a set: the set wins.
- busy = 1 in START, DATA and STOP.
- Latency: falling edge on RXD to rx_valid = 2 + mid + (DATA_BITS+1)*CLKS_PER_BIT + 1 HCLK cycles.
  - Defaults: 2 + 31 + 576 + 1 = 610 cycles.
  - ±1 cycle tolerance at the bench, for edge placement relative to HCLK.
- Counter width: clog2(CLKS_PER_BIT). No other arithmetic.

Test Plan:
- Reset for 5 cycles, then release; drive the 10-bit LSB-first vector 10'b1100100110 at 64 HCLK/bit -> rx_valid rises, rx_data = 8'h93, frame_err = 0, overrun = 0, busy falls.
- Send 0x55 then 0xA0 back-to-back with no idle gap, rx_ready tied high -> two single-cycle rx_valid pulses carrying 0x55 then 0xA0, no flags.
- Low pulse of 20 HCLK cycles on an idle line -> no rx_valid; busy goes high, then returns to 0 after the mid-sample (cycle 31); no flags.
- Frame 0x3C with stop bit forced 0 -> rx_data = 0x3C, rx_valid = 1, frame_err = 1; err_clr pulse -> frame_err = 0.
- rx_ready held low, send 0x11 then 0x22 -> rx_data = 0x22, overrun = 1, rx_valid stays 1; rx_ready for one cycle -> rx_valid = 0.
- Assert HRESETn low mid-way through a frame's data bits (after 4 bits), then release and send 0x7E -> the aborted frame never appears; rx_data = 0x7E; all flags 0.
